// File: rtl/riscv_rf_mp.sv
// riscv_rf_mp: multi-port integer register file with registered, stallable read ports.
// Define RF_BYPASS_EN to forward same-edge write data into the read registers.
module riscv_rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_stall_i,
  input  logic                 wr_stall_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_addr_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i
);

  logic [AW-1:0]       wr_addr_w [NWR];
  logic [XLEN-1:0]     wr_data_w [NWR];
  logic [NWR-1:0]      wr_commit;
  logic [XLEN-1:0]     rf_val    [NREGS];
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD*XLEN-1:0] rd_data_q;

  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
    assign wr_addr_w[gi] = wr_addr_i[gi*AW +: AW];
    assign wr_data_w[gi] = wr_data_i[gi*XLEN +: XLEN];
    // Writes aimed at a hardwired x0 never commit, so they can't leak through the bypass either.
    assign wr_commit[gi] = wr_en_i[gi] & ~wr_stall_i & ~rst &
                           ~((ZERO_REG != 0) && (wr_addr_w[gi] == '0));
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign rf_val[gi] = '0;
    end else begin : g_store
      logic [XLEN-1:0] val_q;
      logic [XLEN-1:0] val_d;

      // Ascending scan: the highest-indexed port hitting this register is applied last and wins.
      always_comb begin
        val_d = val_q;
        for (int w = 0; w < NWR; w++) begin
          if (wr_commit[w] && (wr_addr_w[w] == AW'(gi))) begin
            val_d = wr_data_w[w];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          val_q <= '0;
        end else begin
          val_q <= val_d;
        end
      end

      assign rf_val[gi] = val_q;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = rd_addr_i[gi*AW +: AW];
`ifdef RF_BYPASS_EN
    always_comb begin
      val = rf_val[addr];
      for (int w = 0; w < NWR; w++) begin
        if (wr_commit[w] && (wr_addr_w[w] == addr)) begin
          val = wr_data_w[w];
        end
      end
    end
`else
    assign val = rf_val[addr];
`endif
    assign rd_data_d[gi*XLEN +: XLEN] = val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (!rd_stall_i) begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_riscv_rf_mp.sv
// Self-checking bench for riscv_rf_mp (2 read / 2 write ports, x0 hardwired) against an array model.
module tb_riscv_rf_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                rd_stall;
  logic                wr_stall;
  logic [AW-1:0]       rd_addr [NRD];
  logic [NWR-1:0]      wr_en;
  logic [AW-1:0]       wr_addr [NWR];
  logic [XLEN-1:0]     wr_data [NWR];
  logic [NRD*AW-1:0]   rd_addr_bus;
  logic [NWR*AW-1:0]   wr_addr_bus;
  logic [NWR*XLEN-1:0] wr_data_bus;
  logic [NRD*XLEN-1:0] rd_data_bus;

  logic [XLEN-1:0] mdl [NREGS];
  logic [XLEN-1:0] exp_rd [NRD];
  int errors = 0;
  int checks = 0;

  assign rd_addr_bus = {rd_addr[1], rd_addr[0]};
  assign wr_addr_bus = {wr_addr[1], wr_addr[0]};
  assign wr_data_bus = {wr_data[1], wr_data[0]};

  always #5 clk = ~clk;

  riscv_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_stall_i (rd_stall),
    .wr_stall_i (wr_stall),
    .rd_addr_i  (rd_addr_bus),
    .rd_data_o  (rd_data_bus),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr_bus),
    .wr_data_i  (wr_data_bus)
  );

  function automatic logic [XLEN-1:0] rd_port(input int k);
    return rd_data_bus[k*XLEN +: XLEN];
  endfunction

  // Architectural model: evaluate reads against the pre-edge register state, then commit writes in port order.
  task automatic tick();
    logic [XLEN-1:0] v;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mdl[r] = '0;
      for (int k = 0; k < NRD; k++) exp_rd[k] = '0;
    end else begin
      if (!rd_stall) begin
        for (int k = 0; k < NRD; k++) begin
          v = (rd_addr[k] == 0) ? '0 : mdl[rd_addr[k]];
`ifdef RF_BYPASS_EN
          for (int w = 0; w < NWR; w++)
            if (wr_en[w] && !wr_stall && wr_addr[w] != 0 && wr_addr[w] == rd_addr[k]) v = wr_data[w];
`endif
          exp_rd[k] = v;
        end
      end
      if (!wr_stall)
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && wr_addr[w] != 0) mdl[wr_addr[w]] = wr_data[w];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_stall = 0; wr_stall = 0; wr_en = '0;
    for (int w = 0; w < NWR; w++) begin wr_addr[w] = '0; wr_data[w] = '0; end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); rd_addr[0] = 0; rd_addr[1] = 1;
    tick(); tick();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_port(k) !== 32'h0) begin
        errors++; $display("FAIL reset_out port%0d got=%h exp=%h", k, rd_port(k), 32'h0);
      end
    end
    rst = 0;
    for (int a = 0; a < 4; a += 2) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(a + 1);
      tick();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_port(k) !== 32'h0) begin
          errors++; $display("FAIL reset_read x%0d got=%h exp=%h", a + k, rd_port(k), 32'h0);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 32'hFFFF_FFFF; rd_addr[0] = 0; rd_addr[1] = 0;
    tick();
    checks++;
    if (rd_port(0) !== 32'h0) begin
      errors++; $display("FAIL zero_bypass got=%h exp=%h", rd_port(0), 32'h0);
    end
    wr_en = '0;
    tick();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_port(k) !== 32'h0) begin
        errors++; $display("FAIL zero_read port%0d got=%h exp=%h", k, rd_port(k), 32'h0);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hDEAD_BEEF; rd_addr[0] = 1; rd_addr[1] = 2;
    tick();
    wr_en = '0; rd_addr[0] = 5; rd_addr[1] = 5;
    tick();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_port(k) !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL write_read_x5 port%0d got=%h exp=%h", k, rd_port(k), 32'hDEAD_BEEF);
      end
    end
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(a + 1);
      tick();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_port(k) !== ((a + k == 5) ? 32'hDEAD_BEEF : 32'h0)) begin
          errors++; $display("FAIL sweep x%0d got=%h exp=%h", a + k, rd_port(k),
                             (a + k == 5) ? 32'hDEAD_BEEF : 32'h0);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] want;
`ifdef RF_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'h0;
`endif
    wr_en = 2'b01; wr_addr[0] = 7; wr_data[0] = 32'h1234; rd_addr[0] = 7; rd_addr[1] = 7;
    tick();
    wr_en = '0;
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_port(k) !== want) begin
        errors++; $display("FAIL same_cycle_x7 port%0d got=%h exp=%h", k, rd_port(k), want);
      end
    end
    tick();
    checks++;
    if (rd_port(0) !== 32'h1234) begin
      errors++; $display("FAIL after_same_cycle_x7 got=%h exp=%h", rd_port(0), 32'h1234);
    end
  endtask

  task automatic test_multi_write();
    wr_en = 2'b11; wr_addr[0] = 9; wr_data[0] = 32'hA; wr_addr[1] = 9; wr_data[1] = 32'hB;
    tick();
    wr_en = '0; rd_addr[0] = 9; rd_addr[1] = 9;
    tick();
    checks++;
    if (rd_port(0) !== 32'hB) begin
      errors++; $display("FAIL multi_write_prio got=%h exp=%h", rd_port(0), 32'hB);
    end
    wr_en = 2'b11; wr_addr[0] = 9; wr_data[0] = 32'h11; wr_addr[1] = 10; wr_data[1] = 32'h22;
    tick();
    wr_en = '0; rd_addr[0] = 9; rd_addr[1] = 10;
    tick();
    checks++;
    if (rd_port(0) !== 32'h11 || rd_port(1) !== 32'h22) begin
      errors++; $display("FAIL dual_write got=%h,%h exp=%h,%h", rd_port(0), rd_port(1), 32'h11, 32'h22);
    end
  endtask

  task automatic test_rd_stall();
    rd_addr[0] = 5; rd_addr[1] = 5;
    tick();
    rd_stall = 1; wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'h55;
    for (int c = 0; c < 3; c++) begin
      rd_addr[0] = AW'(c + 1); rd_addr[1] = AW'(c + 20);
      tick();
      checks++;
      if (rd_port(0) !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL stall_hold cyc%0d got=%h exp=%h", c, rd_port(0), 32'hDEAD_BEEF);
      end
    end
    rd_stall = 0; wr_en = '0; rd_addr[0] = 5; rd_addr[1] = 9;
    tick();
    checks++;
    if (rd_port(0) !== 32'h55) begin
      errors++; $display("FAIL stall_release got=%h exp=%h", rd_port(0), 32'h55);
    end
  endtask

  task automatic test_wr_stall();
    wr_stall = 1; wr_en = 2'b11; wr_addr[0] = 3; wr_data[0] = 32'h3333; wr_addr[1] = 3; wr_data[1] = 32'h4444;
    rd_addr[0] = 3; rd_addr[1] = 3;
    tick();
    wr_stall = 0; wr_en = '0;
    tick();
    checks++;
    if (rd_port(0) !== 32'h0) begin
      errors++; $display("FAIL wr_stall_x3 got=%h exp=%h", rd_port(0), 32'h0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      rd_stall = ($urandom_range(0, 99) < 20);
      wr_stall = ($urandom_range(0, 99) < 15);
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 99) < 60);
        wr_addr[w] = AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      for (int k = 0; k < NRD; k++) rd_addr[k] = AW'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_port(k) !== exp_rd[k]) begin
          errors++; $display("FAIL random cyc%0d port%0d got=%h exp=%h", c, k, rd_port(k), exp_rd[k]);
        end
      end
    end
    rst = 0; idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int a = 1; a < NREGS; a++) begin
      wr_en = 2'b01; wr_addr[0] = AW'(a); wr_data[0] = 32'hC000_0000 | 32'(a);
      tick();
    end
    wr_en = '0; rd_addr[0] = 12; rd_addr[1] = 31;
    tick();
    rst = 1; wr_en = 2'b11; wr_addr[0] = 4; wr_data[0] = 32'h77; wr_addr[1] = 6; wr_data[1] = 32'h88;
    tick();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_port(k) !== 32'h0) begin
        errors++; $display("FAIL reset_mid_out port%0d got=%h exp=%h", k, rd_port(k), 32'h0);
      end
    end
    rst = 0; wr_en = '0;
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(a + 1);
      tick();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_port(k) !== 32'h0) begin
          errors++; $display("FAIL reset_mid_read x%0d got=%h exp=%h", a + k, rd_port(k), 32'h0);
        end
      end
    end
  endtask

  initial begin
    rst = 1; idle_inputs(); rd_addr[0] = 0; rd_addr[1] = 0;
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    for (int k = 0; k < NRD; k++) exp_rd[k] = '0;
    test_reset();
    test_zero_reg();
    test_write_read();
    test_same_cycle();
    test_multi_write();
    test_rd_stall();
    test_wr_stall();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_rf_mp.md
# riscv_rf_mp

Parametrised multi-port integer register file for the RV32I core and its wider/multi-issue derivatives. Provides NRD synchronous read ports and NWR write ports over NREGS registers of XLEN bits, with optional hardwired zero register. Read outputs are registered and held under stall. Same-cycle write-to-read forwarding is selectable at compile time. Sits between decode (addresses) and execute (operands), with writeback driving the write ports.

## Interface
- XLEN, 32, register width in bits (>=8)
- NREGS, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREGS)
- NRD, 2, read ports (1..4)
- NWR, 1, write ports (1..2)
- ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rd_stall_i  in  1  1: hold all read outputs; no new read sampled
- wr_stall_i  in  1  1: suppress all writes this cycle
- rd_addr_i  in  NRD*AW  read addresses; port k = bits [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  registered read data; port k = bits [k*XLEN +: XLEN]
- wr_en_i  in  NWR  per-port write enable
- wr_addr_i  in  NWR*AW  write addresses
- wr_data_i  in  NWR*XLEN  write data

## Operation
- Storage: NREGS x XLEN array. With ZERO_REG=1, entry 0 is constant 0 and is not a storage element.
- Write commit: port w writes on posedge when wr_en_i[w] && !wr_stall_i && !rst && !(ZERO_REG && wr_addr==0).
- Same-address multi-write: the highest-indexed port wins; lower ports to that address are dropped.
- Non-written registers keep their values.
- Read: on posedge with !rd_stall_i && !rst, rd_data_o[k] <= value of rd_addr_i[k] as defined below. With rd_stall_i=1, rd_data_o holds, even while writes to the held address commit.
- Read of register 0 with ZERO_REG=1 always returns 0, including under bypass.
- Read value without forwarding: array contents before this edge's writes (old value).
- Multiple read ports to the same address return identical data.
- Reset: all array entries and all rd_data_o cleared to 0. Pending writes in the reset cycle are discarded. Reset overrides both stalls.

## Timing
- Read latency: 1 cycle. Address presented in cycle N (rd_stall_i=0) gives data on rd_data_o in cycle N+1 and holds until the next unstalled edge.
- Write latency: 1 cycle. A write committed at edge N is visible to a read sampled at edge N+1, or at edge N itself when RF_BYPASS_EN is defined.
- Stall release: the first unstalled edge samples the current rd_addr_i against the current array. Addresses presented during the stall are not captured.
- Reset mid-operation: at the first edge with rst=1, outputs are 0. The cycle after rst falls, the array reads 0 everywhere.
- No combinational path from any input to rd_data_o.

## Configuration
- RF_BYPASS_EN defined: when a read sampled at edge N targets an address that a committing write also targets at edge N, rd_data_o gets that write data. The winning port follows the write-priority rule. x0 is still excluded.
- RF_BYPASS_EN undefined: the read returns the pre-write value. The hazard must be covered by external forwarding. No bypass muxes are built.

## Test plan
- Reset, then read x0..x3 on 2 ports -> all rd_data_o = 0. Write x0=32'hFFFF_FFFF (ZERO_REG=1), then read x0 -> 0.
- Write x5=32'hDEAD_BEEF at edge N, read x5 sampled at edge N+1 -> 32'hDEAD_BEEF at N+2. With no write enabled, 31 other registers are unchanged.
- Same-cycle write x7=32'h1234 and read x7 -> rd_data_o=32'h1234 with RF_BYPASS_EN, or the old value (0 after reset) without it.
- NWR=2: both ports write x9 (port0 32'hA, port1 32'hB) -> a read of x9 returns 32'hB. Port0=x9 and port1=x10 -> both values land.
- Read x5 (32'hDEAD_BEEF), then rd_stall_i=1 for 3 cycles while writing x5=32'h55 and changing rd_addr_i -> output holds 32'hDEAD_BEEF. On release, a read of x5 gives 32'h55.
- wr_stall_i=1 with wr_en_i=1 to x3 -> x3 is unchanged. Assert rst mid-stream after writes -> outputs 0 next cycle and every register reads 0.
